aes_sub_bytes_mc: RTL and testbench

Multicycle SubBytes engine for the encryption datapath and the key-expansion path. It accepts a 128-bit AES state through a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per cycle through forward S-box ROM lanes. It then holds the result under a valid/yumi handshake. It is the forward counterpart of the inverse S-box path used by the decryption chip.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_sub_bytes_mc_if.sv | 33 +++
 rtl/aes_sub_bytes_mc_rom_sbox.sv | 72 +++++++
 rtl/aes_sub_bytes_mc.sv | 161 ++++++++++++++++
 tb/tb_aes_sub_bytes_mc.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES datapath types and constants, used by the SubBytes engine,
//   its bus interface and the S-box ROMs.
//   - aes_state_t       : one 128-bit AES state. Byte 0 sits in the MSBs.
//   - aes_byte_t        : one state byte / S-box address.
//   - sub_bytes_state_e : SubBytes engine FSM encoding.
//   - AES_STATE_BYTES   : number of bytes in a state.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_bytes_state_e;

endpackage : aes_pkg

// File: rtl/aes_sub_bytes_mc_if.sv
// -----------------------------------------------------------------------------
// aes_sub_bytes_mc_if
//   Handshake bundle for the multicycle SubBytes engine.
//   Input side (valid/ready) : v_i, data_i, ready_o
//   Output side (valid/yumi) : v_o, data_o, yumi_i
//   inv_i (inverse select)   : present only when AES_SUB_BYTES_INV_EN is defined
//   Modports:
//     slave  - the engine itself
//     master - the producer/consumer driving the engine
// -----------------------------------------------------------------------------
interface aes_sub_bytes_mc_if;

  logic               v_i;
  aes_pkg::aes_state_t data_i;
  logic               ready_o;
  logic               v_o;
  aes_pkg::aes_state_t data_o;
  logic               yumi_i;
`ifdef AES_SUB_BYTES_INV_EN
  logic               inv_i;

  modport slave  (input  v_i, data_i, yumi_i, inv_i,
                  output ready_o, v_o, data_o);
  modport master (output v_i, data_i, yumi_i, inv_i,
                  input  ready_o, v_o, data_o);
`else
  modport slave  (input  v_i, data_i, yumi_i,
                  output ready_o, v_o, data_o);
  modport master (output v_i, data_i, yumi_i,
                  input  ready_o, v_o, data_o);
`endif

endinterface : aes_sub_bytes_mc_if

// File: rtl/aes_sub_bytes_mc_rom_sbox.sv
// -----------------------------------------------------------------------------
// rom_sbox
//   Forward AES S-box as a combinational 256 x 8 ROM.
//   rom_addr [7:0] : input byte
//   data_o   [7:0] : S(rom_addr)
//
// rom_inv_sbox (only when AES_SUB_BYTES_INV_EN is defined)
//   Inverse AES S-box, same port shape as rom_sbox; shared with the
//   decryption datapath.
// -----------------------------------------------------------------------------
module rom_sbox
  import aes_pkg::*;
(
  input  aes_byte_t rom_addr,
  output aes_byte_t data_o
);

  // Entry 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SBOX[rom_addr];

endmodule : rom_sbox

`ifdef AES_SUB_BYTES_INV_EN
module rom_inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t rom_addr,
  output aes_byte_t data_o
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign data_o = INV_SBOX[rom_addr];

endmodule : rom_inv_sbox
`endif

// File: rtl/aes_sub_bytes_mc.sv
// -----------------------------------------------------------------------------
// aes_sub_bytes_mc
//   Multicycle SubBytes engine. A 128-bit state is accepted over valid/ready,
//   BYTES_PER_CYCLE bytes per cycle are pushed through S-box ROM lanes, and
//   the result is held over valid/yumi until the consumer takes it.
//
//   Parameters
//     BYTES_PER_CYCLE : parallel S-box lanes; one of 1, 2, 4, 8, 16.
//   Ports
//     clk_i   : clock, rising edge
//     reset_i : synchronous, active-high reset
//     bus     : aes_sub_bytes_mc_if.slave (v_i/data_i/ready_o,
//               v_o/data_o/yumi_i, and inv_i when enabled)
//   Build option
//     AES_SUB_BYTES_INV_EN : adds inv_i and an inverse ROM per lane; the mode
//                            is captured at acceptance.
//
//   Latency: acceptance in cycle t gives v_o in cycle t+1+16/BYTES_PER_CYCLE.
// -----------------------------------------------------------------------------
module aes_sub_bytes_mc
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  aes_sub_bytes_mc_if.slave bus
);

  localparam int STEPS  = AES_STATE_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LANE_W = 8 * BYTES_PER_CYCLE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  aes_state_t       data_q,  data_d;
  logic [LANE_W-1:0] lane_flat;
`ifdef AES_SUB_BYTES_INV_EN
  logic             mode_q,  mode_d;
`endif

  // ---------------------------------------------------------------------------
  // S-box lanes.
  // The state register rotates left by one lane group per BUSY cycle: lanes
  // always read the top BYTES_PER_CYCLE bytes, and the substituted bytes are
  // appended at the bottom. After 16/B cycles every byte has been substituted
  // exactly once and is back at its original position, so byte cnt*B+j is the
  // byte lane j handles in step cnt. This avoids any per-byte write muxing.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    aes_byte_t lane_in;
    aes_byte_t fwd_out;

    assign lane_in = data_q[127 - 8*j -: 8];

    rom_sbox u_rom_sbox (
      .rom_addr (lane_in),
      .data_o   (fwd_out)
    );

`ifdef AES_SUB_BYTES_INV_EN
    aes_byte_t inv_out;

    rom_inv_sbox u_rom_inv_sbox (
      .rom_addr (lane_in),
      .data_o   (inv_out)
    );

    assign lane_flat[LANE_W - 1 - 8*j -: 8] = mode_q ? inv_out : fwd_out;
`else
    assign lane_flat[LANE_W - 1 - 8*j -: 8] = fwd_out;
`endif
  end : g_lane

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef AES_SUB_BYTES_INV_EN
    mode_d  = mode_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.v_i) begin
          data_d  = bus.data_i;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef AES_SUB_BYTES_INV_EN
          mode_d  = bus.inv_i;
`endif
        end
      end

      ST_BUSY: begin
        // For B=16 the shift clears the register and lane_flat fills it.
        data_d = (data_q << LANE_W) | aes_state_t'(lane_flat);
        if (cnt_q == CNT_LAST) begin
          // Counter holds at its last value; it is cleared on acceptance.
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.yumi_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (reset_i) begin
      // NOTE: the state register is a plain flop bank (not a RAM), so it is
      // cleared here; data_o must read 0 straight out of reset.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef AES_SUB_BYTES_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef AES_SUB_BYTES_INV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of the state register, no input-to-output paths.
  // ---------------------------------------------------------------------------
  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.v_o     = (state_q == ST_DONE);
  assign bus.data_o  = data_q;

endmodule : aes_sub_bytes_mc

// File: tb/tb_aes_sub_bytes_mc.sv
// -----------------------------------------------------------------------------
// tb_aes_sub_bytes_mc
//   Self-checking bench for aes_sub_bytes_mc. Five engines share clock and
//   reset: unit 0 has B=4 and gets the detailed scenarios; units 1..4 cover
//   B=1,2,8,16. Expected results are reference vectors pushed to a scoreboard
//   when a state is driven and popped when the engine raises v_o.
//   With AES_SUB_BYTES_INV_EN defined, inverse-mode scenarios are added.
// -----------------------------------------------------------------------------
module tb_aes_sub_bytes_mc;
  import aes_pkg::*;

  localparam int N_DUT = 5;
  localparam int B_TAB [N_DUT] = '{4, 1, 2, 8, 16};

  localparam aes_state_t VEC_IN   = 128'h00112233445566778899aabbccddeeff;
  localparam aes_state_t VEC_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam aes_state_t ALL_53   = {16{8'h53}};
  localparam aes_state_t ALL_ED   = {16{8'hed}};
  localparam aes_state_t ALL_00   = {16{8'h00}};
  localparam aes_state_t ALL_63   = {16{8'h63}};
  localparam aes_state_t ALL_FF   = {16{8'hff}};

  logic       clk = 1'b0;
  logic       reset;

  logic       drv_v    [N_DUT];
  logic       drv_yumi [N_DUT];
  aes_state_t drv_data [N_DUT];
`ifdef AES_SUB_BYTES_INV_EN
  logic       drv_inv  [N_DUT];
`endif
  logic       obs_ready [N_DUT];
  logic       obs_v     [N_DUT];
  aes_state_t obs_data  [N_DUT];

  int n_checks = 0;
  int n_errors = 0;

  aes_state_t sb_data [$];
  int         sb_lat  [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    aes_sub_bytes_mc_if bus ();

    assign bus.v_i    = drv_v[gi];
    assign bus.data_i = drv_data[gi];
    assign bus.yumi_i = drv_yumi[gi];
`ifdef AES_SUB_BYTES_INV_EN
    assign bus.inv_i  = drv_inv[gi];
`endif
    assign obs_ready[gi] = bus.ready_o;
    assign obs_v[gi]     = bus.v_o;
    assign obs_data[gi]  = bus.data_o;

    aes_sub_bytes_mc #(
      .BYTES_PER_CYCLE (B_TAB[gi])
    ) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus.slave)
    );
  end : g_dut

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one state into a unit, then wait (bounded) for v_o and score it.
  // Latency is counted in clock edges after the acceptance edge: 16/B.
  task automatic run_op(input int unit, input aes_state_t din,
                        input aes_state_t exp, input string tag);
    int         n;
    aes_state_t e;
    int         el;
    n = 0;
    while (!obs_ready[unit] && n < 40) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 128'(obs_ready[unit]), 128'd1);
    sb_data.push_back(exp);
    sb_lat.push_back(AES_STATE_BYTES / B_TAB[unit]);
    drv_data[unit] = din;
    drv_v[unit]    = 1'b1;
    step();
    drv_v[unit]    = 1'b0;
    n = 0;
    while (!obs_v[unit] && n < 40) begin
      step();
      n++;
    end
    e  = sb_data.pop_front();
    el = sb_lat.pop_front();
    check({tag, "_lat"},  128'(n), 128'(el));
    check({tag, "_data"}, obs_data[unit], e);
  endtask

  task automatic take(input int unit, input string tag);
    drv_yumi[unit] = 1'b1;
    step();
    drv_yumi[unit] = 1'b0;
    check({tag, "_ready"}, 128'(obs_ready[unit]), 128'd1);
    check({tag, "_v"},     128'(obs_v[unit]),     128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < N_DUT; u++) begin
      drv_v[u]    = 1'b0;
      drv_yumi[u] = 1'b0;
      drv_data[u] = '0;
`ifdef AES_SUB_BYTES_INV_EN
      drv_inv[u]  = 1'b0;
`endif
    end
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state, first cycle after reset.
    for (int u = 0; u < N_DUT; u++) begin
      check($sformatf("rst_ready_u%0d", u), 128'(obs_ready[u]), 128'd1);
      check($sformatf("rst_v_u%0d", u),     128'(obs_v[u]),     128'd0);
      check($sformatf("rst_data_u%0d", u),  obs_data[u],        ALL_00);
    end

    // yumi_i while idle is ignored.
    drv_yumi[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("idle_yumi_ready", 128'(obs_ready[0]), 128'd1);
      check("idle_yumi_v",     128'(obs_v[0]),     128'd0);
    end
    drv_yumi[0] = 1'b0;

    // Reference vector on B=4, then backpressure for 10 cycles in DONE.
    run_op(0, VEC_IN, VEC_OUT, "b4_vec");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        drv_data[0] = ALL_FF;
        drv_v[0]    = 1'b1;
      end
      if (i == 4) drv_v[0] = 1'b0;
      step();
      check("hold_v",     128'(obs_v[0]),     128'd1);
      check("hold_ready", 128'(obs_ready[0]), 128'd0);
      check("hold_data",  obs_data[0],        VEC_OUT);
    end
    take(0, "b4_take");
    step();
    check("after_take_idle", 128'(obs_ready[0]), 128'd1);

    // Back-to-back operations on B=4.
    run_op(0, ALL_53, ALL_ED, "b4_53");
    take(0, "b4_53_take");
    run_op(0, ALL_00, ALL_63, "b4_00");
    take(0, "b4_00_take");

    // Parameter sweep.
    for (int u = 1; u < N_DUT; u++) begin
      run_op(u, ALL_53, ALL_ED, $sformatf("sweep_b%0d", B_TAB[u]));
      take(u, $sformatf("sweep_b%0d_take", B_TAB[u]));
    end

    // Reset in the middle of BUSY (cnt = 2) on B=4.
    drv_data[0] = ALL_FF;
    drv_v[0]    = 1'b1;
    step();
    drv_v[0]    = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_v",     128'(obs_v[0]),     128'd0);
    check("midrst_ready", 128'(obs_ready[0]), 128'd1);
    check("midrst_data",  obs_data[0],        ALL_00);
    run_op(0, VEC_IN, VEC_OUT, "post_rst");
    take(0, "post_rst_take");

`ifdef AES_SUB_BYTES_INV_EN
    drv_inv[0] = 1'b1;
    run_op(0, ALL_63, ALL_00, "inv");
    take(0, "inv_take");
    fork
      run_op(0, ALL_63, ALL_00, "inv_toggle");
      begin
        @(posedge clk);
        repeat (6) begin
          #1 drv_inv[0] = ~drv_inv[0];
          @(posedge clk);
        end
      end
    join
    take(0, "inv_toggle_take");
    drv_inv[0] = 1'b0;
    run_op(0, ALL_00, ALL_63, "fwd_after_inv");
    take(0, "fwd_after_inv_take");
`endif

    check("sb_empty", 128'(sb_data.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_aes_sub_bytes_mc
